// File: rtl/spi_dac.sv
// spi_dac: free-running serial DAC driver.
// Streams 16-bit frames {CFG_BITS, voltageVal} MSB first. A frame is
// GAP_CYCLES cycles with CS high, then 16 bits of 2*HALF_PERIOD cycles with
// CS low. The DAC samples sdo on sck rising edges, and sdo only moves when
// sck falls, so the data is always settled before the DAC samples it.
// Handshake: none. There is no start request. voltageVal is sampled once per
// frame, on the clk edge where CS falls. Changes outside that edge are only
// picked up by the next frame.
`timescale 1ns/1ps
module spi_dac #(
   parameter logic [3:0] CFG_BITS    = 4'b0011,
   parameter int         HALF_PERIOD = 1,
   parameter int         GAP_CYCLES  = 4
) (
   input  logic        rst,
   input  logic        clk,
   output logic        sdo,
   output logic        CS,
   input  logic [11:0] voltageVal,
   output logic        sck
);

   localparam int HW = $clog2(HALF_PERIOD + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic {
      ST_GAP  = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t          r_state,    w_state;
   logic [GW-1:0]   r_gap_cnt,  w_gap_cnt;
   logic [HW-1:0]   r_half_cnt, w_half_cnt;
   logic [3:0]      r_bit_cnt,  w_bit_cnt;
   logic [15:0]     r_shift,    w_shift;
   logic            r_sck,      w_sck;
   logic            r_cs,       w_cs;

   // sdo is the top bit of the shift register. That register is cleared
   // whenever CS is high, so sdo reads 0 between frames.
   assign sdo = r_shift[15];
   assign CS  = r_cs;
   assign sck = r_sck;

   // State and output registers. Reset drops the frame at once, with no clock needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_GAP;
         r_gap_cnt  <= '0;
         r_half_cnt <= '0;
         r_bit_cnt  <= 4'd0;
         r_shift    <= 16'd0;
         r_sck      <= 1'b0;
         r_cs       <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_gap_cnt  <= w_gap_cnt;
         r_half_cnt <= w_half_cnt;
         r_bit_cnt  <= w_bit_cnt;
         r_shift    <= w_shift;
         r_sck      <= w_sck;
         r_cs       <= w_cs;
      end
   end

   // Next-state and next-output logic for the GAP/SEND sequencer.
   always_comb begin
      w_state    = r_state;
      w_gap_cnt  = r_gap_cnt;
      w_half_cnt = r_half_cnt;
      w_bit_cnt  = r_bit_cnt;
      w_shift    = r_shift;
      w_sck      = r_sck;
      w_cs       = r_cs;
      case (r_state)
         ST_GAP: begin
            w_sck   = 1'b0;
            w_cs    = 1'b1;
            w_shift = 16'd0;
            if (r_gap_cnt == GAP_LAST) begin
               // CS falls here, and the frame word is captured on this same edge.
               w_state    = ST_SEND;
               w_gap_cnt  = '0;
               w_half_cnt = '0;
               w_bit_cnt  = 4'd15;
               w_shift    = {CFG_BITS, voltageVal};
               w_cs       = 1'b0;
            end else begin
               w_gap_cnt = r_gap_cnt + 1'b1;
            end
         end
         ST_SEND: begin
            if (r_half_cnt == HP_LAST) begin
               w_half_cnt = '0;
               if (!r_sck) begin
                  w_sck = 1'b1;
               end else if (r_bit_cnt == 4'd0) begin
                  // The high phase of the last bit is done, so the frame ends.
                  w_state   = ST_GAP;
                  w_gap_cnt = '0;
                  w_sck     = 1'b0;
                  w_cs      = 1'b1;
                  w_shift   = 16'd0;
               end else begin
                  // sck falls, and the next bit moves onto sdo.
                  w_sck     = 1'b0;
                  w_bit_cnt = r_bit_cnt - 4'd1;
                  w_shift   = {r_shift[14:0], 1'b0};
               end
            end else begin
               w_half_cnt = r_half_cnt + 1'b1;
            end
         end
         default: begin
            w_state = ST_GAP;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_dac.sv
// tb_spi_dac: self-checking bench for spi_dac with default timing
// (HALF_PERIOD=1, GAP_CYCLES=4).
`timescale 1ns/1ps
module tb_spi_dac;

  localparam logic [3:0] CFG_BITS = 4'b0011;
  localparam int FRAME_PERIOD = 36;
  localparam int LOW_CYCLES   = 32;
  localparam int WAIT_LIMIT   = 200;

  typedef struct {
    logic [11:0] v;
    logic [15:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] voltage_val = 12'd0;
  logic        sdo, cs, sck;

  always #5 clk = ~clk;

  spi_dac #(.CFG_BITS(CFG_BITS), .HALF_PERIOD(1), .GAP_CYCLES(4)) dut (
    .rst(rst), .clk(clk), .sdo(sdo), .CS(cs), .voltageVal(voltage_val), .sck(sck)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame monitor ----------------
  // Frames are rebuilt from the pins by sampling on negedge. The word a frame
  // should carry is the code present at the clk edge where CS fell.
  logic [11:0] vv_at_edge;
  always @(posedge clk) vv_at_edge <= voltage_val;

  int          cyc = 0;
  int          last_fall = -1;
  int          low_len = 0;
  int          gap_bad = 0;
  int          stab_bad = 0;
  int          mon_rises = 0;
  int          mon_starts = 0;
  int          mon_dones = 0;
  logic        in_frame = 1'b0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0;
  logic [15:0] word = 16'd0, exp_word = 16'd0, mon_last_word = 16'd0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      in_frame  = 1'b0;
      last_fall = -1;
      prev_cs   = 1'b1;
      prev_sck  = 1'b0;
      prev_sdo  = 1'b0;
      gap_bad   = 0;
    end else begin
      if (cs && (sck || sdo)) gap_bad++;
      if (prev_cs && !cs) begin
        check("gap_idle_lines", gap_bad, 0);
        gap_bad = 0;
        if (last_fall >= 0) check("frame_period", cyc - last_fall, FRAME_PERIOD);
        last_fall = cyc;
        in_frame  = 1'b1;
        word      = 16'd0;
        mon_rises = 0;
        low_len   = 0;
        stab_bad  = 0;
        exp_word  = {CFG_BITS, vv_at_edge};
        exp_q.push_back(exp_word);
        mon_starts++;
      end else if (in_frame && !cs && (sdo !== prev_sdo) && !(prev_sck && !sck)) begin
        stab_bad++;
      end
      if (in_frame && !cs) begin
        low_len++;
        if (!prev_sck && sck) begin
          mon_rises++;
          word = {word[14:0], sdo};
        end
      end
      if (in_frame && cs && !prev_cs) begin
        if (exp_q.size() > 0) check("frame_word_model", word, exp_q.pop_front());
        check("sck_rises", mon_rises, 16);
        check("cs_low_cycles", low_len, LOW_CYCLES);
        check("sdo_stable", stab_bad, 0);
        mon_last_word = word;
        in_frame = 1'b0;
        mon_dones++;
      end
      prev_cs  = cs;
      prev_sck = sck;
      prev_sdo = sdo;
    end
    if (!rst) exp_q.delete();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start();
    int s0;
    int n;
    s0 = mon_starts;
    n = 0;
    while (mon_starts == s0 && n < WAIT_LIMIT) begin tick(); n++; end
    check("frame_start_seen", (mon_starts != s0), 1);
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = mon_dones;
    n = 0;
    while (mon_dones == d0 && n < WAIT_LIMIT) begin tick(); n++; end
    check("frame_done_seen", (mon_dones != d0), 1);
  endtask

  // Change the code while a frame is running, then return the word carried
  // by the next complete frame.
  task automatic run_frame(input logic [11:0] v, output logic [15:0] w);
    wait_start();
    voltage_val = v;
    wait_start();
    wait_done();
    w = mon_last_word;
  endtask

  // ---------------- test sequence ----------------
  vec_t        tbl[7];
  logic [15:0] got;
  logic [11:0] rv;
  int          n;

  initial begin
    tbl[0] = '{12'h000, 16'h3000};
    tbl[1] = '{12'h0C8, 16'h30C8};
    tbl[2] = '{12'hBB8, 16'h3BB8};
    tbl[3] = '{12'hFFF, 16'h3FFF};
    tbl[4] = '{12'h001, 16'h3001};
    tbl[5] = '{12'h555, 16'h3555};
    tbl[6] = '{12'hAAA, 16'h3AAA};

    // Reset holds idle levels while the clock runs.
    #1 rst = 1'b0;
    repeat (3) tick();
    check("reset_cs", cs, 1);
    check("reset_sck", sck, 0);
    check("reset_sdo", sdo, 0);

    // CS falls on the 4th rising edge after release.
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("cs_after_release", cs, (k < 4) ? 1 : 0);
    end
    check("first_bit_msb", sdo, CFG_BITS[3]);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].v, got);
      check("table_word", got, tbl[i].exp);
    end

    // Mid-frame change: current frame keeps 1, next frame carries 5.
    wait_start();
    voltage_val = 12'd1;
    wait_start();
    repeat (5) tick();
    voltage_val = 12'd5;
    wait_done();
    check("midchange_old", mon_last_word, 16'h3001);
    wait_done();
    check("midchange_new", mon_last_word, 16'h3005);

    // Random codes against the arithmetic model: prefix 3 in the top nibble.
    for (int i = 0; i < 16; i++) begin
      rv = 12'($urandom_range(0, 4095));
      run_frame(rv, got);
      check("random_word", got, 32'(3 * 4096 + int'(rv)));
    end

    // Reset at bit 7: lines go idle before the next clk edge.
    voltage_val = 12'h9A5;
    wait_start();
    n = 0;
    while (mon_rises < 8 && n < WAIT_LIMIT) begin tick(); n++; end
    check("reached_bit7", (mon_rises >= 8), 1);
    rst = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_sdo", sdo, 0);
    voltage_val = 12'h6E1;
    repeat (3) tick();
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("cs_after_abort", cs, (k < 4) ? 1 : 0);
    end
    wait_done();
    check("post_abort_word", mon_last_word, 16'h36E1);
    wait_done();
    check("post_abort_next", mon_last_word, 16'h36E1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #1000000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
